// File: rtl/rope_shot_controller.sv
// Life cycle of one player rope shot (launch, per-frame growth, optional super-rope
// hold at the ceiling, kill) plus the registered per-pixel bracket for the rope bitmap.
module rope_shot_controller #(
   parameter int ROPE_WIDTH  = 7,
   parameter int FLOOR_Y     = 447,
   parameter int CEILING_Y   = 16,
   parameter int SPEED       = 4,
   parameter int HOLD_FRAMES = 90,
   parameter int X_MAX       = 639
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        startOfFrame,
   input  logic        fireKey,
   input  logic        superEn,
   input  logic [10:0] launchX,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic        ropeHit,
   output logic        InsideRectangle,
   output logic [10:0] offsetX,
   output logic [10:0] offsetY,
   output logic        superRope,
   output logic        ropeActive,
   output logic [10:0] ropeTopY
);

   localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
   localparam logic [10:0]   L_FLOOR     = 11'(FLOOR_Y);
   localparam logic [10:0]   L_CEIL      = 11'(CEILING_Y);
   localparam logic [10:0]   L_LAUNCH_Y  = 11'(FLOOR_Y - SPEED);
   localparam logic [10:0]   L_X_CLAMP   = 11'(X_MAX - ROPE_WIDTH + 1);
   localparam logic [HW-1:0] L_HOLD_INIT = HW'(HOLD_FRAMES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EXTEND = 2'd1,
      S_HOLD   = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic          r_fire_d;
   logic [10:0]   r_rope_x;
   logic [10:0]   r_top_y;
   logic [HW-1:0] r_hold_cnt;
   logic          r_super;
   logic          r_inside;
   logic [10:0]   r_offset_x;
   logic [10:0]   r_offset_y;

   logic          w_fire_edge;
   logic          w_active;
   logic [10:0]   w_rope_x_nxt;
   logic [10:0]   w_top_y_nxt;
   logic [HW-1:0] w_hold_nxt;
   logic          w_super_nxt;
   logic signed [11:0] w_top_dec;
   logic [11:0]   w_right_x;
   logic          w_in_rect;

   assign w_fire_edge = fireKey & ~r_fire_d;
   assign w_active    = (r_state != S_IDLE);
   // Signed so a step past row 0 compares as negative instead of wrapping.
   assign w_top_dec   = $signed({1'b0, r_top_y}) - $signed(12'(SPEED));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_fire_d   <= 1'b0;
         r_rope_x   <= '0;
         r_top_y    <= '0;
         r_hold_cnt <= '0;
         r_super    <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_fire_d   <= fireKey;
         r_rope_x   <= w_rope_x_nxt;
         r_top_y    <= w_top_y_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_super    <= w_super_nxt;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_rope_x_nxt = r_rope_x;
      w_top_y_nxt  = r_top_y;
      w_hold_nxt   = r_hold_cnt;
      w_super_nxt  = r_super;
      unique case (r_state)
         S_IDLE: begin
            if (w_fire_edge) begin
               w_rope_x_nxt = (launchX > L_X_CLAMP) ? L_X_CLAMP : launchX;
               w_super_nxt  = superEn;
               w_top_y_nxt  = L_LAUNCH_Y;
               w_next_state = S_EXTEND;
            end
         end
         S_EXTEND: begin
            if (ropeHit) begin
               w_next_state = S_IDLE;
            end else if (startOfFrame) begin
               if (w_top_dec > $signed({1'b0, L_CEIL})) begin
                  w_top_y_nxt = w_top_dec[10:0];
               end else begin
                  w_top_y_nxt = L_CEIL;
                  if (r_super) begin
                     w_next_state = S_HOLD;
                     w_hold_nxt   = L_HOLD_INIT;
                  end else begin
                     w_next_state = S_IDLE;
                  end
               end
            end
         end
         S_HOLD: begin
            w_top_y_nxt = L_CEIL;
            if (ropeHit) begin
               w_next_state = S_IDLE;
            end else if (startOfFrame) begin
               if (r_hold_cnt == '0) w_next_state = S_IDLE;
               else                  w_hold_nxt   = r_hold_cnt - 1'b1;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
      // Every path back to IDLE parks the rope at the floor and drops the power-up.
      if (w_next_state == S_IDLE && r_state != S_IDLE) begin
         w_top_y_nxt = L_FLOOR;
         w_super_nxt = 1'b0;
      end
   end

   // Bracket sees only registered shot state, so ropeHit never reaches it combinationally.
   assign w_right_x = {1'b0, r_rope_x} + 12'(ROPE_WIDTH - 1);
   assign w_in_rect = w_active
                    & (pixelX >= r_rope_x) & ({1'b0, pixelX} <= w_right_x)
                    & (pixelY >= r_top_y)  & (pixelY < L_FLOOR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_inside   <= 1'b0;
         r_offset_x <= '0;
         r_offset_y <= '0;
      end else begin
         r_inside   <= w_in_rect;
         r_offset_x <= w_in_rect ? (pixelX - r_rope_x) : 11'd0;
         r_offset_y <= w_in_rect ? (pixelY - r_top_y)  : 11'd0;
      end
   end

   assign InsideRectangle = r_inside;
   assign offsetX         = r_offset_x;
   assign offsetY         = r_offset_y;
   assign superRope       = r_super;
   assign ropeActive      = w_active;
   assign ropeTopY        = w_active ? r_top_y : L_FLOOR;

endmodule

// File: tb/tb_rope_shot_controller.sv
// Directed and randomized bench for rope_shot_controller against a frame-counting
// reference model of the rope shot.
module tb_rope_shot_controller;

   localparam int FLOOR = 447;
   localparam int CEIL  = 16;
   localparam int SPD   = 4;
   localparam int HOLD  = 90;
   localparam int XCLMP = 633;
   localparam int RW    = 7;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        startOfFrame = 1'b0;
   logic        fireKey = 1'b0;
   logic        superEn = 1'b0;
   logic [10:0] launchX = '0;
   logic [10:0] pixelX = '0;
   logic [10:0] pixelY = '0;
   logic        ropeHit = 1'b0;
   logic        InsideRectangle;
   logic [10:0] offsetX;
   logic [10:0] offsetY;
   logic        superRope;
   logic        ropeActive;
   logic [10:0] ropeTopY;

   int checks = 0;
   int errors = 0;

   // Reference model: a shot is described by its column, frames grown, and frames left at the ceiling.
   bit m_fire_d, m_active, m_holding, m_super;
   int m_x, m_top, m_frames, m_hold_left;
   bit exp_in;
   int exp_ox, exp_oy;

   rope_shot_controller dut (
      .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .fireKey(fireKey),
      .superEn(superEn), .launchX(launchX), .pixelX(pixelX), .pixelY(pixelY),
      .ropeHit(ropeHit), .InsideRectangle(InsideRectangle), .offsetX(offsetX),
      .offsetY(offsetY), .superRope(superRope), .ropeActive(ropeActive), .ropeTopY(ropeTopY)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_fire_d = 0; m_active = 0; m_holding = 0; m_super = 0;
      m_x = 0; m_top = FLOOR; m_frames = 0; m_hold_left = 0;
      exp_in = 0; exp_ox = 0; exp_oy = 0;
   endtask

   task automatic end_shot();
      m_active = 0; m_holding = 0; m_super = 0; m_top = FLOOR;
   endtask

   task automatic model_clock(input bit sof, input bit fire, input bit hit, input bit sup,
                              input int lx, input int px, input int py);
      bit edge_seen;
      int n;
      exp_in = m_active && px >= m_x && px <= m_x + RW - 1 && py >= m_top && py < FLOOR;
      exp_ox = exp_in ? px - m_x : 0;
      exp_oy = exp_in ? py - m_top : 0;
      edge_seen = fire && !m_fire_d;
      m_fire_d = fire;
      if (!m_active) begin
         if (edge_seen) begin
            m_active = 1; m_holding = 0; m_super = sup; m_frames = 0;
            m_x = (lx > XCLMP) ? XCLMP : lx;
            m_top = FLOOR - SPD;
         end
      end else if (hit) begin
         end_shot();
      end else if (sof) begin
         if (!m_holding) begin
            m_frames++;
            n = FLOOR - SPD * (m_frames + 1);
            if (n > CEIL) m_top = n;
            else if (m_super) begin
               m_holding = 1; m_top = CEIL; m_hold_left = HOLD;
            end else end_shot();
         end else begin
            m_hold_left--;
            if (m_hold_left == 0) end_shot();
         end
      end
   endtask

   task automatic check_all();
      chk("ropeActive", 11'(ropeActive), 11'(m_active));
      chk("ropeTopY", ropeTopY, m_active ? 11'(m_top) : 11'(FLOOR));
      chk("superRope", 11'(superRope), 11'(m_super));
      chk("InsideRectangle", 11'(InsideRectangle), 11'(exp_in));
      chk("offsetX", offsetX, 11'(exp_ox));
      chk("offsetY", offsetY, 11'(exp_oy));
   endtask

   task automatic step(input bit sof, input bit fire, input bit hit, input bit sup,
                       input logic [10:0] lx, input logic [10:0] px, input logic [10:0] py);
      startOfFrame = sof; fireKey = fire; ropeHit = hit; superEn = sup;
      launchX = lx; pixelX = px; pixelY = py;
      @(posedge clk);
      model_clock(sof, fire, hit, sup, int'(lx), int'(px), int'(py));
      @(negedge clk);
      check_all();
      startOfFrame = 0; ropeHit = 0;
   endtask

   task automatic rand_pix(output logic [10:0] px, output logic [10:0] py);
      int bx, by;
      bx = m_active ? m_x : 300;
      by = m_active ? m_top : 440;
      case ($urandom_range(0, 3))
         0: begin px = 11'($urandom_range(0, 700)); py = 11'($urandom_range(0, 480)); end
         1: begin px = 11'(bx - 2 + $urandom_range(0, 10)); py = 11'(by - 2 + $urandom_range(0, 6)); end
         2: begin px = 11'(bx + $urandom_range(0, 6)); py = 11'($urandom_range(440, 450)); end
         default: begin px = 11'(bx + $urandom_range(0, 6)); py = 11'(by + $urandom_range(0, 60)); end
      endcase
   endtask

   task automatic frame(input bit fire, input bit sup, input logic [10:0] lx);
      logic [10:0] px, py;
      rand_pix(px, py); step(1, fire, 0, sup, lx, px, py);
      rand_pix(px, py); step(0, fire, 0, sup, lx, px, py);
      rand_pix(px, py); step(0, fire, 0, sup, lx, px, py);
   endtask

   initial begin
      int n, launches;
      bit prev, f, sof, hit, sup;
      logic [10:0] px, py;
      model_reset();

      // Reset state
      repeat (2) @(negedge clk);
      check_all();
      reset = 1'b0;
      step(0, 0, 0, 0, 11'd300, 11'd0, 11'd0);

      // 1: plain shot climbs to 19 after 106 frames, then retires
      step(0, 1, 0, 0, 11'd300, 11'd300, 11'd445);
      chk("t1_active_launch", 11'(ropeActive), 11'd1);
      chk("t1_top_launch", ropeTopY, 11'd443);
      for (int i = 0; i < 106; i++) frame(0, 0, 11'd300);
      chk("t1_top_106", ropeTopY, 11'd19);
      frame(0, 0, 11'd300);
      chk("t1_idle_active", 11'(ropeActive), 11'd0);
      chk("t1_idle_top", ropeTopY, 11'd447);

      // 2: super shot holds 90 frames at the ceiling
      step(0, 1, 0, 1, 11'd100, 11'd0, 11'd0);
      chk("t2_super_launch", 11'(superRope), 11'd1);
      n = 0;
      while (ropeActive === 1'b1 && n < 400) begin
         frame(0, 0, 11'd100);
         n++;
         if (n == 150) begin
            chk("t2_hold_top", ropeTopY, 11'd16);
            chk("t2_hold_super", 11'(superRope), 11'd1);
         end
      end
      chk("t2_frames_to_idle", 11'(n), 11'd197);
      chk("t2_super_after", 11'(superRope), 11'd0);

      // 3: hit coinciding with a frame pulse wins
      step(0, 1, 0, 0, 11'd50, 11'd0, 11'd0);
      for (int i = 0; i < 5; i++) frame(0, 0, 11'd50);
      step(1, 0, 1, 0, 11'd50, 11'd52, 11'd430);
      chk("t3_hit_active", 11'(ropeActive), 11'd0);
      chk("t3_hit_top", ropeTopY, 11'd447);

      // 4: held fire key launches once; later edge relaunches
      launches = 0; prev = 0;
      for (int i = 0; i < 150; i++) begin
         if (i == 20) step(0, 0, 0, 0, 11'd200, 11'd0, 11'd0);
         frame(1, 0, 11'd200);
         if (ropeActive && !prev) launches++;
         prev = ropeActive;
      end
      chk("t4_launches", 11'(launches), 11'd1);
      chk("t4_idle_held", 11'(ropeActive), 11'd0);
      step(0, 0, 0, 0, 11'd200, 11'd0, 11'd0);
      step(0, 1, 0, 0, 11'd200, 11'd0, 11'd0);
      chk("t4_relaunch", 11'(ropeActive), 11'd1);
      step(0, 0, 1, 0, 11'd200, 11'd0, 11'd0);

      // 5: right-edge clamp and bracket corners
      step(0, 1, 0, 0, 11'd636, 11'd0, 11'd0);
      for (int i = 0; i < 10; i++) frame(0, 0, 11'd636);
      chk("t5_top", ropeTopY, 11'd403);
      step(0, 0, 0, 0, 11'd636, 11'd633, 11'd440);
      chk("t5_in_left", 11'(InsideRectangle), 11'd1);
      chk("t5_ox_left", offsetX, 11'd0);
      chk("t5_oy_left", offsetY, 11'd37);
      step(0, 0, 0, 0, 11'd636, 11'd639, 11'd403);
      chk("t5_in_right", 11'(InsideRectangle), 11'd1);
      chk("t5_ox_right", offsetX, 11'd6);
      step(0, 0, 0, 0, 11'd636, 11'd640, 11'd440);
      chk("t5_out", 11'(InsideRectangle), 11'd0);
      chk("t5_out_ox", offsetX, 11'd0);
      chk("t5_out_oy", offsetY, 11'd0);
      step(0, 0, 0, 0, 11'd636, 11'd635, 11'd447);
      chk("t5_floor_row", 11'(InsideRectangle), 11'd0);
      step(0, 0, 1, 0, 11'd636, 11'd0, 11'd0);

      // 6: asynchronous reset while holding
      step(0, 1, 0, 1, 11'd400, 11'd0, 11'd0);
      for (int i = 0; i < 110; i++) frame(0, 1, 11'd400);
      chk("t6_holding", ropeTopY, 11'd16);
      #2 reset = 1'b1;
      #1;
      model_reset();
      chk("t6_rst_active", 11'(ropeActive), 11'd0);
      chk("t6_rst_top", ropeTopY, 11'd447);
      chk("t6_rst_super", 11'(superRope), 11'd0);
      check_all();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         frame(0, 0, 11'd400);
         chk("t6_no_shot", 11'(ropeActive), 11'd0);
      end

      // Randomized traffic
      f = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) f = ~f;
         sof = ($urandom_range(0, 3) == 0);
         hit = ($urandom_range(0, 63) == 0);
         sup = $urandom_range(0, 1);
         rand_pix(px, py);
         step(sof, f, hit, sup, 11'($urandom_range(0, 2047)), px, py);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
